// File: rtl/pwm_ramp_ctrl.sv
// Host-programmable PWM duty ramp controller: forwards period writes and steps
// the duty cycle toward a target at a programmable interval.
module pwm_ramp_ctrl #(
  parameter int W = 20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         host_wr_n,
  input  logic [1:0]   host_addr,
  input  logic [W-1:0] host_data,
  output logic         pwm_wr_n,
  output logic         pwm_addr,
  output logic [W-1:0] pwm_data,
  output logic [W-1:0] cur_duty,
  output logic         busy,
  output logic         done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_WR_PERIOD,
    S_WR_DUTY,
    S_DONE
  } state_e;

  localparam logic [W-1:0] ONE = W'(1);

  state_e       state_q, state_d;
  state_e       ret_q, ret_d;
  logic [W-1:0] period_q, period_d;
  logic [W-1:0] target_q, target_d;
  logic [W-1:0] step_q, step_d;
  logic [W-1:0] interval_q, interval_d;
  logic [W-1:0] cur_duty_q, cur_duty_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic         pend_q, pend_d;
  logic         ramp_q, ramp_d;
  logic         pwm_wr_n_q, pwm_wr_n_d;
  logic         pwm_addr_q, pwm_addr_d;
  logic [W-1:0] pwm_data_q, pwm_data_d;

  logic         up;
  logic [W-1:0] step_eff, interval_eff, diff, delta, next_duty;

  // Next duty moves toward target by at most one step and never past it.
  always_comb begin
    step_eff     = (step_q == '0) ? ONE : step_q;
    interval_eff = (interval_q == '0) ? ONE : interval_q;
    up           = target_q > cur_duty_q;
    diff         = up ? (target_q - cur_duty_q) : (cur_duty_q - target_q);
    delta        = (step_eff < diff) ? step_eff : diff;
    next_duty    = up ? (cur_duty_q + delta) : (cur_duty_q - delta);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ret_q      <= S_IDLE;
      period_q   <= '0;
      target_q   <= '0;
      step_q     <= '0;
      interval_q <= '0;
      cur_duty_q <= '0;
      cnt_q      <= '0;
      pend_q     <= 1'b0;
      ramp_q     <= 1'b0;
      pwm_wr_n_q <= 1'b1;
      pwm_addr_q <= 1'b0;
      pwm_data_q <= '0;
    end else begin
      state_q    <= state_d;
      ret_q      <= ret_d;
      period_q   <= period_d;
      target_q   <= target_d;
      step_q     <= step_d;
      interval_q <= interval_d;
      cur_duty_q <= cur_duty_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      ramp_q     <= ramp_d;
      pwm_wr_n_q <= pwm_wr_n_d;
      pwm_addr_q <= pwm_addr_d;
      pwm_data_q <= pwm_data_d;
    end
  end

  // NOTE: every signal gets a default before the case so no path infers a latch.
  always_comb begin
    state_d    = state_q;
    ret_d      = ret_q;
    period_d   = period_q;
    target_d   = target_q;
    step_d     = step_q;
    interval_d = interval_q;
    cur_duty_d = cur_duty_q;
    cnt_d      = cnt_q;
    pend_d     = pend_q;
    ramp_d     = ramp_q;

    case (state_q)
      S_IDLE: begin
        if (pend_q) begin
          state_d = S_WR_PERIOD;
          ret_d   = S_IDLE;
        end else if (ramp_q) begin
          ramp_d = 1'b0;
          if (target_q != cur_duty_q) begin
            state_d = S_WAIT;
            cnt_d   = interval_eff;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_WAIT: begin
        // The WAIT cycle that notices a period write still counts; the counter
        // holds only across the WR_PERIOD slot, delaying the ramp by one cycle.
        if (cnt_q > ONE) cnt_d = cnt_q - ONE;
        if (pend_q) begin
          state_d = S_WR_PERIOD;
          ret_d   = S_WAIT;
        end else if (cnt_q <= ONE) begin
          state_d    = S_WR_DUTY;
          cur_duty_d = next_duty;
        end
      end
      S_WR_PERIOD: begin
        pend_d  = 1'b0;
        state_d = ret_q;
      end
      S_WR_DUTY: begin
        if (cur_duty_q == target_q) begin
          state_d = S_DONE;
        end else begin
          state_d = S_WAIT;
          cnt_d   = interval_eff;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Host writes override any clear in the same cycle so none is lost.
    if (!host_wr_n) begin
      case (host_addr)
        2'd0: begin
          period_d = host_data;
          pend_d   = 1'b1;
        end
        2'd1: begin
          target_d = host_data;
          ramp_d   = 1'b1;
        end
        2'd2: step_d     = host_data;
        2'd3: interval_d = host_data;
      endcase
    end
  end

  always_comb begin
    pwm_wr_n_d = 1'b1;
    pwm_addr_d = pwm_addr_q;
    pwm_data_d = pwm_data_q;
    if (state_d == S_WR_PERIOD) begin
      pwm_wr_n_d = 1'b0;
      pwm_addr_d = 1'b0;
      pwm_data_d = period_q;
    end else if (state_d == S_WR_DUTY) begin
      pwm_wr_n_d = 1'b0;
      pwm_addr_d = 1'b1;
      pwm_data_d = next_duty;
    end
    busy = (state_q != S_IDLE) || pend_q || ramp_q;
    done = (state_q == S_DONE);
  end

  assign pwm_wr_n = pwm_wr_n_q;
  assign pwm_addr = pwm_addr_q;
  assign pwm_data = pwm_data_q;
  assign cur_duty = cur_duty_q;

endmodule

// File: doc/pwm_ramp_ctrl.md
PWM_RAMP_CTRL -- requirements
Module: pwm_ramp_ctrl

Interface
REQ-001 Parameter: W, default 20, data width of period/duty/step/interval registers and both data buses.
REQ-002 clk  input  1  single system clock; all state changes on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 host_wr_n  input  1  host write strobe, active low, one write per low cycle.
REQ-005 host_addr  input  2  host register select: 0=period, 1=target duty, 2=step size, 3=step interval.
REQ-006 host_data  input  W  host write data.
REQ-007 pwm_wr_n  output  1  write strobe to PWM generator, active low, registered.
REQ-008 pwm_addr  output  1  PWM register select: 0=period, 1=duty, registered.
REQ-009 pwm_data  output  W  PWM write data, registered.
REQ-010 cur_duty  output  W  last duty value written to the PWM generator.
REQ-011 busy  output  1  high while a period write is pending or a ramp is in progress.
REQ-012 done  output  1  one-cycle pulse when cur_duty reaches target.

Function
REQ-013 Host writes land in the addressed register at the clock edge where host_wr_n=0; the new value is visible to the FSM from the next cycle.
REQ-014 Host write to address 0 sets pend_period; host write to address 1 sets ramp_req.
REQ-015 FSM states: IDLE, WAIT, WR_PERIOD, WR_DUTY, DONE.
REQ-016 IDLE: pend_period=1 -> WR_PERIOD (priority); else ramp_req=1 and target!=cur_duty -> WAIT with interval counter loaded; else ramp_req=1 and target==cur_duty -> DONE; ramp_req clears on leaving IDLE.
REQ-017 WAIT: pend_period=1 -> WR_PERIOD, interval counter frozen; else counter decrements; at counter==1 -> WR_DUTY.
REQ-018 Interval value 0 behaves as 1; WAIT lasts exactly max(interval,1) cycles absent period preemption.
REQ-019 WR_PERIOD: exactly one cycle with pwm_wr_n=0, pwm_addr=0, pwm_data=period; clears pend_period; returns to the state it was entered from.
REQ-020 WR_DUTY: exactly one cycle with pwm_wr_n=0, pwm_addr=1, pwm_data=next; cur_duty<=next.
REQ-021 next = cur_duty + min(step, target-cur_duty) when target>cur_duty, cur_duty - min(step, cur_duty-target) otherwise; step 0 behaves as 1; no overshoot, no wrap, unsigned W-bit arithmetic.
REQ-022 After WR_DUTY: next==target -> DONE; else WAIT with counter reloaded.
REQ-023 DONE: done=1 for one cycle -> IDLE.
REQ-024 Target rewritten mid-ramp: new target used at the next WR_DUTY computation; interval timing not restarted; direction may reverse.
REQ-025 Step/interval rewritten mid-ramp: step takes effect at next WR_DUTY; interval at next reload.
REQ-026 Host write coinciding with a WR_* cycle is captured; it does not alter that cycle's pwm_data.
REQ-027 Outside WR_PERIOD/WR_DUTY: pwm_wr_n=1; pwm_addr and pwm_data hold their last values.
REQ-028 busy = (state!=IDLE) or pend_period or ramp_req.
REQ-029 At most one PWM write per cycle; period and duty writes never overlap.

Reset
REQ-030 rst=1 forces, asynchronously: state=IDLE, period=duty target=step=interval=cur_duty=0, pend_period=ramp_req=0, counter=0, pwm_wr_n=1, pwm_addr=0, pwm_data=0, busy=0, done=0.
REQ-031 rst asserted mid-ramp or mid-write aborts immediately; no further PWM write occurs until new host writes after rst deasserts.

Verification
REQ-032 Write period=1000 -> next cycle busy=1, following cycle pwm_wr_n=0, pwm_addr=0, pwm_data=1000 for exactly one cycle, then busy=0.
REQ-033 step=100, interval=4, target=250 from cur_duty=0 -> duty writes 100, 200, 250 spaced 5 cycles apart (4 WAIT + 1 WR_DUTY); done pulses once after 250.
REQ-034 Ramp down: cur_duty=250, step=100, target=0 -> writes 150, 50, 0; no underflow.
REQ-035 Period write during WAIT of a ramp -> period write issued next cycle, interval counter frozen one cycle, subsequent duty write delayed by exactly one cycle.
REQ-036 step=0, interval=0, target=3 from 0 -> duty writes 1, 2, 3 on consecutive 2-cycle spacing (WAIT 1 + WR_DUTY 1); target==cur_duty write -> done only, no PWM write.
REQ-037 rst pulse during WAIT at cur_duty=200 -> all outputs at reset values same cycle; no PWM write after release without new host writes.
